// File: rtl/stopwatch_bcd_counter_if.sv
// Control inputs and BCD time outputs of the stopwatch counter stage.
// The slave side is the counter itself; the master side drives ticks and controls.
`timescale 1ns/1ps
interface stopwatch_bcd_counter_if;
   logic       tick_1hz;
   logic       tick_2hz;
   logic       pause_btn;
   logic       adjust;
   logic       sel;
   logic [3:0] seconds;
   logic [3:0] deca_seconds;
   logic [3:0] minutes;
   logic [3:0] deca_minutes;
   logic       paused;
   logic       rollover;

   modport slave (
      input  tick_1hz, tick_2hz, pause_btn, adjust, sel,
      output seconds, deca_seconds, minutes, deca_minutes, paused, rollover
   );

   modport master (
      output tick_1hz, tick_2hz, pause_btn, adjust, sel,
      input  seconds, deca_seconds, minutes, deca_minutes, paused, rollover
   );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS BCD time-keeping stage: counts on the 1 Hz tick, adjusts a field on the
// 2 Hz tick, and toggles run/pause on each rising edge of the debounced button.
`timescale 1ns/1ps
module stopwatch_bcd_counter #(
   parameter int MIN_TENS_MAX   = 5,
   parameter bit PAUSE_AT_RESET = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   stopwatch_bcd_counter_if.slave   bus
);
   localparam logic [3:0] MIN_TENS = 4'(MIN_TENS_MAX);

   logic [3:0] sec_q, dsec_q, min_q, dmin_q;
   logic       paused_q, rollover_q, pause_btn_q;

   logic pause_rise;
   logic sec_wrap, dsec_wrap, min_wrap, dmin_wrap;
   logic count_en, adj_sec, adj_min, min_step;

   // Wrap tests use >= so a digit can never walk past its legal BCD range.
   assign sec_wrap   = (sec_q  >= 4'd9);
   assign dsec_wrap  = (dsec_q >= 4'd5);
   assign min_wrap   = (min_q  >= 4'd9);
   assign dmin_wrap  = (dmin_q >= MIN_TENS);

   assign pause_rise = bus.pause_btn & ~pause_btn_q;
   // The tick sees paused as it was before any toggle landing on the same edge.
   assign count_en   = ~bus.adjust & bus.tick_1hz & ~paused_q;
   assign adj_sec    =  bus.adjust & bus.tick_2hz &  bus.sel;
   assign adj_min    =  bus.adjust & bus.tick_2hz & ~bus.sel;
   assign min_step   = (count_en & sec_wrap & dsec_wrap) | adj_min;

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
         sec_q       <= 4'd0;
         dsec_q      <= 4'd0;
         min_q       <= 4'd0;
         dmin_q      <= 4'd0;
         paused_q    <= PAUSE_AT_RESET;
         rollover_q  <= 1'b0;
         pause_btn_q <= bus.pause_btn;
      end else begin
         pause_btn_q <= bus.pause_btn;
         paused_q    <= paused_q ^ pause_rise;
         rollover_q  <= count_en & sec_wrap & dsec_wrap & min_wrap & dmin_wrap;

         if (count_en || adj_sec) begin
            sec_q <= sec_wrap ? 4'd0 : sec_q + 4'd1;
            if (sec_wrap)
               dsec_q <= dsec_wrap ? 4'd0 : dsec_q + 4'd1;
         end

         if (min_step) begin
            min_q <= min_wrap ? 4'd0 : min_q + 4'd1;
            if (min_wrap)
               dmin_q <= dmin_wrap ? 4'd0 : dmin_q + 4'd1;
         end
      end
   end

   assign bus.seconds      = sec_q;
   assign bus.deca_seconds = dsec_q;
   assign bus.minutes      = min_q;
   assign bus.deca_minutes = dmin_q;
   assign bus.paused       = paused_q;
   assign bus.rollover     = rollover_q;
endmodule

// File: doc/stopwatch_bcd_counter.md
Name: stopwatch_bcd_counter

Overview:
- Time-keeping stage that feeds the four seven_seg decoders and the display multiplexer in the stopwatch.
- Holds MM:SS as four BCD digits. Advances one second per 1 Hz tick while running.
- Toggles run/pause on each press of the debounced pause button.
- In adjust mode, increments the selected field (seconds or minutes) at 2 Hz.
- Single-clock design: tick inputs are one-cycle enables from the clock generator, not derived clocks.

Parameters:
- MIN_TENS_MAX, 5: highest deca_minutes value. Minutes wrap after {MIN_TENS_MAX}9 (e.g. 59).
- PAUSE_AT_RESET, 0: value loaded into paused on reset (0 = running).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick_1hz  in  1  one-cycle count enable, 1 Hz.
- tick_2hz  in  1  one-cycle adjust enable, 2 Hz.
- pause_btn  in  1  debounced pause button level; each rising edge toggles pause.
- adjust  in  1  1 = adjust mode.
- sel  in  1  adjust target: 1 = seconds field, 0 = minutes field.
- seconds  out  4  BCD seconds units, 0-9.
- deca_seconds  out  4  BCD seconds tens, 0-5.
- minutes  out  4  BCD minutes units, 0-9.
- deca_minutes  out  4  BCD minutes tens, 0-MIN_TENS_MAX.
- paused  out  1  1 = counting halted.
- rollover  out  1  one-cycle pulse on normal-mode wrap to 00:00.

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset values: all digits 0, paused = PAUSE_AT_RESET, rollover = 0.
- Reset also loads the pause-edge register with the current pause_btn, so a button held through reset does not toggle on release.
- Pause control:
  - Rising edge = pause_btn 1 while its registered copy is 0.
  - A rising edge toggles paused on the following clock edge (1-cycle latency).
  - A held level produces only one toggle.
  - Toggling is active in both modes.
- Normal mode (adjust = 0):
  - On tick_1hz with paused = 0, increment MM:SS by one, with outputs updated on that same edge.
  - Carry chain:
    - seconds 9 -> 0, carry to deca_seconds.
    - deca_seconds 5 -> 0, carry to minutes.
    - minutes 9 -> 0, carry to deca_minutes.
    - deca_minutes MIN_TENS_MAX -> 0.
  - {MIN_TENS_MAX}9:59 -> 00:00, with rollover = 1 for exactly that cycle.
  - tick_2hz is ignored.
- Adjust mode (adjust = 1):
  - tick_1hz is ignored and paused has no effect on adjusting.
  - On tick_2hz with sel = 1: seconds field +1, 59 -> 00, no carry into minutes.
  - On tick_2hz with sel = 0: minutes field +1, {MIN_TENS_MAX}9 -> 00, seconds unchanged.
  - rollover is never asserted in adjust mode.
- Simultaneous events:
  - tick_1hz and tick_2hz in the same cycle: only the tick relevant to the current mode acts.
  - Pause edge coinciding with tick_1hz: the tick is evaluated against the pre-toggle paused value.
- Mode or sel changes take effect on the next tick. Digit state is preserved across mode switches.
- rst asserted mid-count or mid-adjust clears state on that edge. No tick is lost or doubled after rst deasserts.
- Outputs are registered and never leave legal BCD range.
- rollover is 0 in every cycle except the wrap cycle.

Test Plan:
1. Reset, adjust = 0, 60 tick_1hz pulses -> digits read 01:00 (minutes = 1, all others 0), paused = 0, rollover never high.
2. Drive 3599 ticks from 00:00 -> 59:59; next tick -> 00:00 with rollover = 1 for exactly one cycle.
3. At 00:05, pulse pause_btn high for 10 cycles, then 5 ticks -> paused = 1 after one cycle, digits stay 00:05. Second press then 1 tick -> paused = 0, 00:06.
4. At 12:58, adjust = 1, sel = 1, 3 tick_2hz pulses -> 12:01, no minute carry. Then sel = 0 with 48 tick_2hz pulses -> 00:01. tick_1hz pulses interleaved throughout have no effect.
5. tick_1hz and tick_2hz asserted together in normal mode -> single +1 second. Same in adjust mode with sel = 1 -> single +1 second, via tick_2hz only.
6. pause_btn held high across rst assertion and release, at 34:17 -> all digits 0, paused = PAUSE_AT_RESET, no toggle on release. rst mid-adjust -> 00:00 the same edge.
